array_ctrl: RTL

- Sequencer for the HEIGHT x WIDTH binary-parallel systolic array: runs one output tile (clear, accumulate over cfg_k, drain, read-out) per start.
- Drives only the array edge controls: en_i/clr_i per row, and en_w/clr_w/en_o/clr_o per column. Applies the diagonal skew with internal shift registers; the PEs forward the controls from there.
- Also issues read strobes and indices to the ifm/wght feeder buffers.

---
 rtl/array_ctrl_if.sv | 23 ++
 rtl/array_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/array_ctrl_if.sv
// Host/feeder side of the systolic array sequencer: tile request, status and
// feeder read handshake.
interface array_ctrl_if #(
   parameter int KW = 11
);
   logic          start;
   logic [KW-1:0] cfg_k;
   logic          src_valid;
   logic          rd_en;
   logic [KW-1:0] rd_idx;
   logic          busy;
   logic          done;

   modport master (
      output start, cfg_k, src_valid,
      input  rd_en, rd_idx, busy, done
   );

   modport slave (
      input  start, cfg_k, src_valid,
      output rd_en, rd_idx, busy, done
   );
endinterface

// File: rtl/array_ctrl.sv
// Tile sequencer for a HEIGHT x WIDTH systolic array: clear, accumulate over k,
// drain, read-out. Edge controls are diagonally skewed by internal shift registers.
module array_ctrl #(
   parameter int HEIGHT = 12,
   parameter int WIDTH  = 14,
   parameter int KMAX   = 1024,
   parameter int KW     = $clog2(KMAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   array_ctrl_if.slave       bus,
   output logic [HEIGHT-1:0] en_i,
   output logic [HEIGHT-1:0] clr_i,
   output logic [WIDTH-1:0]  en_w,
   output logic [WIDTH-1:0]  clr_w,
   output logic [WIDTH-1:0]  en_o,
   output logic [WIDTH-1:0]  clr_o
);
   localparam int DMAX = (HEIGHT > WIDTH) ? HEIGHT : WIDTH;
   localparam int CW   = $clog2(HEIGHT + WIDTH + 1);

   localparam logic [KW-1:0] KMAX_V     = KW'(KMAX);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(HEIGHT + WIDTH - 3);
   localparam logic [CW-1:0] OUT_LAST   = CW'(HEIGHT - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_OUT     = 3'd4;
   localparam logic [2:0] S_FLUSH   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]      state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [KW-1:0]   kcnt_q, kcnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DMAX-1:0] en_sr_q, en_sr_d;
   logic [DMAX-1:0] clr_sr_q, clr_sr_d;
   logic [WIDTH-1:0] eno_sr_q, eno_sr_d;
   logic            rd_en;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      kcnt_d  = kcnt_q;
      cnt_d   = cnt_q;
      rd_en   = (state_q == S_COMPUTE) && bus.src_valid;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CLEAR;
               k_d     = (bus.cfg_k > KMAX_V) ? KMAX_V : bus.cfg_k;
               kcnt_d  = '0;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = (k_q == '0) ? S_DRAIN : S_COMPUTE;
         end
         S_COMPUTE: begin
            // k_cnt stops at k-1 so rd_idx keeps showing the last index read.
            if (rd_en) begin
               if (kcnt_q == k_q - 1'b1) state_d = S_DRAIN;
               else                      kcnt_d  = kcnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = S_OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_OUT: begin
            if (cnt_q == OUT_LAST) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FLUSH: begin
            if (cnt_q == FLUSH_LAST) state_d = S_DONE;
            else                     cnt_d   = cnt_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Bit 0 of each shift register is the registered master itself.
      en_sr_d  = {en_sr_q[DMAX-2:0], rd_en};
      clr_sr_d = {clr_sr_q[DMAX-2:0], state_q == S_CLEAR};
      eno_sr_d = {eno_sr_q[WIDTH-2:0], state_q == S_OUT};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         kcnt_q   <= '0;
         cnt_q    <= '0;
         en_sr_q  <= '0;
         clr_sr_q <= '0;
         eno_sr_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         kcnt_q   <= kcnt_d;
         cnt_q    <= cnt_d;
         en_sr_q  <= en_sr_d;
         clr_sr_q <= clr_sr_d;
         eno_sr_q <= eno_sr_d;
      end
   end

   assign bus.rd_en  = rd_en;
   assign bus.rd_idx = kcnt_q;
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE);

   assign en_i  = en_sr_q[HEIGHT-1:0];
   assign clr_i = clr_sr_q[HEIGHT-1:0];
   assign en_w  = en_sr_q[WIDTH-1:0];
   assign clr_w = clr_sr_q[WIDTH-1:0];
   assign en_o  = eno_sr_q;
   assign clr_o = clr_sr_q[WIDTH-1:0];
endmodule
